// File: rtl/ds_scratchpad_check.sv
// DS18B20 scratchpad checker: bit-serial Dallas CRC-8 over bytes 0..7, bus-fault
// rejection, and validated temperature / power-on flag / hysteretic alarm / error count.
module ds_scratchpad_check #(
  parameter logic signed [15:0] T_HI  = 16'sd1280,
  parameter logic signed [15:0] T_LO  = 16'sd1200,
  parameter int                 ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [71:0]       T_data,
  output logic              busy,
  output logic              temp_valid,
  output logic [15:0]       temp_raw,
  output logic              por_flag,
  output logic              alarm,
  output logic              crc_err,
  output logic              bus_fault,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_CRC, S_CHECK, S_RESULT} state_t;
  typedef enum logic [1:0] {RES_OK, RES_CRC, RES_BUS} res_t;

  state_t            state_q, state_d;
  res_t              res_q, res_d;
  logic              done_dly_q, done_dly_d;
  logic              pending_q, pending_d;
  logic [71:0]       last_q, last_d;
  logic [71:0]       shadow_q, shadow_d;
  logic [7:0]        crc_q, crc_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [15:0]       temp_q, temp_d;
  logic              por_q, por_d;
  logic              alarm_q, alarm_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              trig;
  logic signed [15:0] new_temp;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    crc8_step = (crc >> 1) ^ (fb ? 8'h8C : 8'h00);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    sat_inc = (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  assign trig     = done && (!done_dly_q || (T_data != last_q));
  assign new_temp = shadow_q[15:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (trig) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_CRC;
      S_CRC:     if (cnt_q == 6'd63) state_d = S_CHECK;
      S_CHECK:   state_d = S_RESULT;
      S_RESULT:  state_d = (pending_q || trig) ? S_CAPTURE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    temp_valid = (state_q == S_RESULT) && (res_q == RES_OK);
    crc_err    = (state_q == S_RESULT) && (res_q == RES_CRC);
    bus_fault  = (state_q == S_RESULT) && (res_q == RES_BUS);
  end

  // A trigger seen in CAPTURE is satisfied by the word being captured that cycle.
  always_comb begin
    done_dly_d = done;
    pending_d  = pending_q;
    last_d     = last_q;
    shadow_d   = shadow_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    temp_d     = temp_q;
    por_d      = por_q;
    alarm_d    = alarm_q;
    err_d      = err_q;
    case (state_q)
      S_CAPTURE: begin
        shadow_d = T_data;
        last_d   = T_data;
        crc_d    = 8'h00;
        cnt_d    = 6'd0;
      end
      S_CRC: begin
        crc_d = crc8_step(crc_q, shadow_q[cnt_q]);
        cnt_d = cnt_q + 6'd1;
        if (trig) pending_d = 1'b1;
      end
      S_CHECK: begin
        if (trig) pending_d = 1'b1;
        if (shadow_q == '0 || shadow_q == '1) begin
          res_d = RES_BUS;
          err_d = sat_inc(err_q);
        end else if (crc_q != shadow_q[71:64]) begin
          res_d = RES_CRC;
          err_d = sat_inc(err_q);
        end else begin
          res_d  = RES_OK;
          temp_d = shadow_q[15:0];
          por_d  = (shadow_q[15:0] == 16'h0550);
          if (new_temp >= T_HI)      alarm_d = 1'b1;
          else if (new_temp <= T_LO) alarm_d = 1'b0;
        end
      end
      S_RESULT:  pending_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_dly_q <= 1'b0;
      pending_q  <= 1'b0;
      last_q     <= '0;
      shadow_q   <= '0;
      crc_q      <= '0;
      cnt_q      <= '0;
      res_q      <= RES_OK;
      temp_q     <= '0;
      por_q      <= 1'b0;
      alarm_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      done_dly_q <= done_dly_d;
      pending_q  <= pending_d;
      last_q     <= last_d;
      shadow_q   <= shadow_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      temp_q     <= temp_d;
      por_q      <= por_d;
      alarm_q    <= alarm_d;
      err_q      <= err_d;
    end
  end

  assign temp_raw = temp_q;
  assign por_flag = por_q;
  assign alarm    = alarm_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_ds_scratchpad_check.sv
// Directed bench for ds_scratchpad_check: one task per scenario, inline checks.
module tb_ds_scratchpad_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        done = 1'b0;
  logic [71:0] T_data = '0;
  logic        busy, temp_valid, por_flag, alarm, crc_err, bus_fault;
  logic [15:0] temp_raw;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  // TH/TL bytes ordered 4Bh,46h so that 1Ch is the matching CRC of bytes 0..7.
  localparam logic [71:0] W0 = 72'h1C_10_0C_FF_7F_46_4B_05_50;
  localparam logic [47:0] MID = 48'h10_0C_FF_7F_46_4B;

  ds_scratchpad_check #(.T_HI(16'sd1280), .T_LO(16'sd1200), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .done(done), .T_data(T_data), .busy(busy),
    .temp_valid(temp_valid), .temp_raw(temp_raw), .por_flag(por_flag),
    .alarm(alarm), .crc_err(crc_err), .bus_fault(bus_fault), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_crc(input logic [63:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < 64; k++) begin
      fb = c[0] ^ d[k];
      c  = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  function automatic logic [71:0] mk_word(input logic [15:0] t);
    logic [63:0] body;
    body = {MID, t};
    return {ref_crc(body), body};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rising edge of done with word w; watch a bounded window for result pulses.
  task automatic run_word(input logic [71:0] w, input int win,
                          output int lat, output int nv, output int nc, output int nb);
    lat = -1; nv = 0; nc = 0; nb = 0;
    done = 1'b0;
    tick();
    T_data = w;
    done   = 1'b1;
    for (int i = 1; i <= win; i++) begin
      tick();
      if ((temp_valid || crc_err || bus_fault) && lat < 0) lat = i;
      nv += int'(temp_valid);
      nc += int'(crc_err);
      nb += int'(bus_fault);
    end
    done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({busy, temp_valid, por_flag, alarm, crc_err, bus_fault, temp_raw, err_cnt} !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b tv=%b por=%b al=%b ce=%b bf=%b t=%h e=%0d want all 0",
               busy, temp_valid, por_flag, alarm, crc_err, bus_fault, temp_raw, err_cnt);
    end
  endtask

  task automatic test_valid();
    int lat, nv, nc, nb;
    run_word(W0, 90, lat, nv, nc, nb);
    total++; if (lat !== 67) begin bad++; $display("FAIL valid_latency got %0d want 67", lat); end
    total++; if ({nv, nc, nb} !== {32'd1, 32'd0, 32'd0}) begin bad++; $display("FAIL valid_pulses got v=%0d c=%0d b=%0d want 1/0/0", nv, nc, nb); end
    total++; if (temp_raw !== 16'h0550) begin bad++; $display("FAIL valid_temp got %h want 0550", temp_raw); end
    total++; if ({por_flag, alarm} !== 2'b11) begin bad++; $display("FAIL valid_flags got por=%b al=%b want 1/1", por_flag, alarm); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL valid_errcnt got %0d want 0", err_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL valid_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_crc_err();
    int lat, nv, nc, nb;
    logic [71:0] w;
    w = W0;
    w[71:64] = 8'h1D;
    run_word(w, 90, lat, nv, nc, nb);
    total++; if ({nv, nc, nb} !== {32'd0, 32'd1, 32'd0}) begin bad++; $display("FAIL crcerr_pulses got v=%0d c=%0d b=%0d want 0/1/0", nv, nc, nb); end
    total++; if (lat !== 67) begin bad++; $display("FAIL crcerr_latency got %0d want 67", lat); end
    total++; if ({temp_raw, alarm, por_flag} !== {16'h0550, 2'b11}) begin bad++; $display("FAIL crcerr_hold got t=%h al=%b por=%b want 0550/1/1", temp_raw, alarm, por_flag); end
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL crcerr_errcnt got %0d want 1", err_cnt); end
  endtask

  task automatic test_bus_fault();
    int lat, nv, nc, nb;
    int sb, sc;
    sb = 0; sc = 0;
    run_word(72'h0, 90, lat, nv, nc, nb);
    sb += nb; sc += nc + nv;
    run_word({72{1'b1}}, 90, lat, nv, nc, nb);
    sb += nb; sc += nc + nv;
    total++; if (sb !== 2) begin bad++; $display("FAIL busfault_count got %0d want 2", sb); end
    total++; if (sc !== 0) begin bad++; $display("FAIL busfault_other got %0d want 0", sc); end
    total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL busfault_errcnt got %0d want 3", err_cnt); end
    total++; if (temp_raw !== 16'h0550) begin bad++; $display("FAIL busfault_temp got %h want 0550", temp_raw); end
  endtask

  task automatic test_hysteresis();
    logic [15:0] temps [4] = '{16'd1280, 16'd1250, 16'd1200, 16'd1250};
    logic        exp_al [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int lat, nv, nc, nb;
    for (int i = 0; i < 4; i++) begin
      run_word(mk_word(temps[i]), 90, lat, nv, nc, nb);
      total++;
      if (nv !== 1 || temp_raw !== temps[i] || alarm !== exp_al[i]) begin
        bad++;
        $display("FAIL hyst_step%0d got v=%0d t=%0d al=%b want 1/%0d/%b", i, nv, temp_raw, alarm, temps[i], exp_al[i]);
      end
    end
  endtask

  task automatic test_negative();
    int lat, nv, nc, nb;
    run_word(mk_word(16'hFF5E), 90, lat, nv, nc, nb);
    total++; if (nv !== 1) begin bad++; $display("FAIL neg_valid got %0d want 1", nv); end
    total++; if ($signed(temp_raw) !== -16'sd162) begin bad++; $display("FAIL neg_temp got %0d want -162", $signed(temp_raw)); end
    total++; if ({alarm, por_flag} !== 2'b00) begin bad++; $display("FAIL neg_flags got al=%b por=%b want 0/0", alarm, por_flag); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] first_t;
    int nv;
    nv = 0; first_t = 16'hxxxx;
    done = 1'b0;
    tick();
    T_data = mk_word(16'd100);
    done   = 1'b1;
    for (int i = 1; i <= 250; i++) begin
      if (i == 20) T_data = mk_word(16'd200);
      if (i == 40) T_data = mk_word(16'd300);
      tick();
      if (temp_valid) begin
        if (nv == 0) first_t = temp_raw;
        nv++;
      end
    end
    total++; if (nv !== 2) begin bad++; $display("FAIL b2b_count got %0d want 2", nv); end
    total++; if (first_t !== 16'd100) begin bad++; $display("FAIL b2b_first got %0d want 100", first_t); end
    total++; if (temp_raw !== 16'd300) begin bad++; $display("FAIL b2b_last got %0d want 300", temp_raw); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got %b want 0", busy); end
    done = 1'b0;
    tick();
  endtask

  task automatic test_err_saturation();
    int lat, nv, nc, nb, ncs;
    logic [71:0] w;
    w = mk_word(16'd300);
    w[71:64] = ~w[71:64];
    ncs = 0;
    for (int r = 0; r < 300; r++) begin
      run_word(w, 72, lat, nv, nc, nb);
      ncs += nc;
    end
    total++; if (ncs !== 300) begin bad++; $display("FAIL sat_crc_pulses got %0d want 300", ncs); end
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_errcnt got %0d want 255", err_cnt); end
    total++; if (temp_raw !== 16'd300) begin bad++; $display("FAIL sat_temp got %0d want 300", temp_raw); end
  endtask

  task automatic test_reset_mid();
    int np;
    np = 0;
    done = 1'b0;
    tick();
    T_data = W0;
    done   = 1'b1;
    for (int i = 0; i < 32; i++) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    rst  = 1'b1;
    done = 1'b0;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, temp_valid, por_flag, alarm, crc_err, bus_fault, temp_raw, err_cnt} !== 30'd0) begin
      bad++;
      $display("FAIL midrst_outputs got busy=%b t=%h al=%b por=%b e=%0d want all 0", busy, temp_raw, alarm, por_flag, err_cnt);
    end
    for (int i = 0; i < 90; i++) begin
      tick();
      np += int'(temp_valid) + int'(crc_err) + int'(bus_fault);
    end
    total++; if (np !== 0) begin bad++; $display("FAIL midrst_pulses got %0d want 0", np); end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_crc_err();
    test_bus_fault();
    test_hysteresis();
    test_negative();
    test_back_to_back();
    test_err_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
